// File: rtl/lif_block_n.sv
// Leaky integrate-and-fire neuron over N_IN masked W-bit channels, with step enable and refractory period.
// Latency: sampled inputs reach potential/spike on the following update edge; no backpressure, one step per en.
module lif_block_n #(
    parameter int N_IN       = 4,
    parameter int W          = 4,
    parameter int ACC_W      = 8,
    parameter int LEAK_SHIFT = 2,
    parameter int THRESHOLD  = 40,
    parameter int REFRAC     = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [N_IN*W-1:0]   in_flat,
    input  logic [N_IN-1:0]     in_mask,
    output logic [W-1:0]        out,
    output logic                spike,
    output logic [ACC_W-1:0]    potential,
    output logic                refractory
);

    localparam int SUM_W = W + $clog2(N_IN);

    typedef enum logic {INTEGRATE, REFRACTORY} state_t;

    logic [W-1:0]     buf_in [N_IN];
    logic             en_d;
    logic [ACC_W-1:0] v, v_nxt;
    state_t           state, state_nxt;
    logic [3:0]       cnt, cnt_nxt;
    logic             spike_nxt;
    logic [SUM_W-1:0] sum;
    logic [ACC_W-1:0] leaked;
    logic [ACC_W:0]   acc;
    logic [ACC_W-1:0] nxt_sat;

    // Stage 0: masking is applied here, so a mask change only matters on the next sampling cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_IN; i++) buf_in[i] <= '0;
            en_d <= 1'b0;
        end else begin
            en_d <= en;
            if (en) begin
                for (int i = 0; i < N_IN; i++)
                    buf_in[i] <= in_mask[i] ? in_flat[i*W +: W] : '0;
            end
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < N_IN; i++) sum = sum + SUM_W'(buf_in[i]);
    end

    always_comb begin
        leaked  = v - (v >> LEAK_SHIFT);
        acc     = {1'b0, leaked} + (ACC_W+1)'(sum);
        nxt_sat = acc[ACC_W] ? '1 : acc[ACC_W-1:0];
    end

    always_comb begin
        v_nxt     = v;
        state_nxt = state;
        cnt_nxt   = cnt;
        spike_nxt = 1'b0;
        if (en_d) begin
            case (state)
                INTEGRATE: begin
                    if (nxt_sat >= ACC_W'(THRESHOLD)) begin
                        v_nxt     = '0;
                        spike_nxt = 1'b1;
                        cnt_nxt   = 4'(REFRAC);
                        state_nxt = (REFRAC != 0) ? REFRACTORY : INTEGRATE;
                    end else begin
                        v_nxt = nxt_sat;
                    end
                end
                REFRACTORY: begin
                    // Input is discarded while refractory; cnt counts the skipped steps.
                    v_nxt   = '0;
                    cnt_nxt = cnt - 4'd1;
                    if (cnt == 4'd1) state_nxt = INTEGRATE;
                end
                default: state_nxt = INTEGRATE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INTEGRATE;
            v     <= '0;
            cnt   <= '0;
            spike <= 1'b0;
        end else begin
            state <= state_nxt;
            v     <= v_nxt;
            cnt   <= cnt_nxt;
            spike <= spike_nxt;
        end
    end

    assign out        = {W{spike}};
    assign potential  = v;
    assign refractory = (state == REFRACTORY);

endmodule
